// File: rtl/button_event_pkg.sv
// Shared constants, reset values and register decode for button_event_unit.
// The REL_EVENT register is only decoded when the caller enables it (BTN_RELEASE_EVENT_EN).
package button_event_pkg;

  localparam int unsigned MAX_BTN = 16;

  localparam logic [31:0] OFF_STATE     = 32'h0;
  localparam logic [31:0] OFF_EVENT     = 32'h4;
  localparam logic [31:0] OFF_IRQ_EN    = 32'h8;
  localparam logic [31:0] OFF_REL_EVENT = 32'hC;

  localparam logic [MAX_BTN-1:0] RST_EVENT     = '0;
  localparam logic [MAX_BTN-1:0] RST_IRQ_EN    = '0;
  localparam logic [MAX_BTN-1:0] RST_REL_EVENT = '0;
  localparam logic [31:0]        RST_RDATA     = '0;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_STATE,
    SEL_EVENT,
    SEL_IRQ_EN,
    SEL_REL_EVENT
  } reg_sel_e;

  // Exact-match decode; an address below base wraps to a large offset and misses.
  function automatic reg_sel_e decode_reg(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic        rel_en);
    logic [31:0] offs;
    reg_sel_e    sel;
    offs = addr - base;
    sel  = SEL_NONE;
    case (offs)
      OFF_STATE:     sel = SEL_STATE;
      OFF_EVENT:     sel = SEL_EVENT;
      OFF_IRQ_EN:    sel = SEL_IRQ_EN;
      OFF_REL_EVENT: sel = rel_en ? SEL_REL_EVENT : SEL_NONE;
      default:       sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer, stability counter and debounced level,
// with single-cycle rise/fall pulses registered alongside the level change.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_comb begin
    // NOTE: every _d gets a default first, so no path through this block can infer a latch.
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = ~level_q;
        rise_d  = ~level_q;
        fall_d  = level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values; the sync chain depends on it.
      sync_q  <= {sync_q[0], btn_raw_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/button_event_unit.sv
// Debounced button block with STATE/EVENT/IRQ_EN registers on a simple valid/ready bus.
// Define BTN_RELEASE_EVENT_EN to add the REL_EVENT register (release events) at offset 0xC.
module button_event_unit
  import button_event_pkg::*;
#(
  parameter int unsigned N_BTN           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter logic [31:0] BASE_ADDR       = 32'h4000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [N_BTN-1:0]  btn_raw,
  input  logic              iomem_valid,
  output logic              iomem_ready,
  input  logic [3:0]        iomem_wstrb,
  input  logic [31:0]       iomem_addr,
  input  logic [31:0]       iomem_wdata,
  output logic [31:0]       iomem_rdata,
  output logic              irq
);

`ifdef BTN_RELEASE_EVENT_EN
  localparam logic REL_EN = 1'b1;
`else
  localparam logic REL_EN = 1'b0;
`endif

  logic [N_BTN-1:0] level, rise, fall;
  logic [N_BTN-1:0] wmask, wbits;

  logic [N_BTN-1:0] event_q, event_d;
  logic [N_BTN-1:0] irq_en_q, irq_en_d;
  logic             ready_q, ready_d;
  logic [31:0]      rdata_q, rdata_d;

  reg_sel_e sel;
  logic     hit, wr_en;

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk      (clk),
      .rst_n    (resetn),
      .btn_raw_i(btn_raw[g]),
      .level_o  (level[g]),
      .rise_o   (rise[g]),
      .fall_o   (fall[g])
    );
    // Only byte lanes 0 and 1 carry button bits.
    assign wmask[g] = (g < 8) ? iomem_wstrb[0] : iomem_wstrb[1];
  end

  assign wbits = iomem_wdata[N_BTN-1:0] & wmask;

  always_comb begin
    sel   = decode_reg(iomem_addr, BASE_ADDR, REL_EN);
    hit   = iomem_valid && !ready_q && (sel != SEL_NONE);
    wr_en = hit && (iomem_wstrb != 4'b0000);
  end

`ifdef BTN_RELEASE_EVENT_EN
  logic [N_BTN-1:0] rel_q, rel_d;

  always_comb begin
    rel_d = rel_q | fall;
    if (wr_en && sel == SEL_REL_EVENT) rel_d = (rel_q & ~wbits) | fall;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rel_q <= RST_REL_EVENT[N_BTN-1:0];
    else         rel_q <= rel_d;
  end

  assign irq = |(event_q & irq_en_q) | |(rel_q & irq_en_q);
`else
  logic unused_fall;
  assign unused_fall = ^fall;
  assign irq         = |(event_q & irq_en_q);
`endif

  always_comb begin
    // A new rising edge is OR-ed in after the clear, so set wins over W1C.
    event_d = event_q | rise;
    if (wr_en && sel == SEL_EVENT) event_d = (event_q & ~wbits) | rise;

    irq_en_d = irq_en_q;
    if (wr_en && sel == SEL_IRQ_EN) irq_en_d = (irq_en_q & ~wmask) | wbits;

    ready_d = hit;
    rdata_d = '0;
    if (hit) begin
      case (sel)
        SEL_STATE:     rdata_d = 32'(level);
        SEL_EVENT:     rdata_d = 32'(event_q);
        SEL_IRQ_EN:    rdata_d = 32'(irq_en_q);
`ifdef BTN_RELEASE_EVENT_EN
        SEL_REL_EVENT: rdata_d = 32'(rel_q);
`endif
        default:       rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      event_q  <= RST_EVENT[N_BTN-1:0];
      irq_en_q <= RST_IRQ_EN[N_BTN-1:0];
      ready_q  <= 1'b0;
      rdata_q  <= RST_RDATA;
    end else begin
      event_q  <= event_d;
      irq_en_q <= irq_en_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;

  logic unused_bus;
  assign unused_bus = ^{iomem_wdata, iomem_wstrb};

endmodule

// File: tb/tb_button_event_unit.sv
// Directed bench for button_event_unit with DEBOUNCE_CYCLES=4, N_BTN=5.
// Release-event checks switch on when BTN_RELEASE_EVENT_EN is defined.
module tb_button_event_unit;

  localparam logic [31:0] BASE = 32'h4000;

  logic        clk;
  logic        resetn;
  logic [4:0]  btn_raw;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  button_event_unit #(
    .N_BTN          (5),
    .DEBOUNCE_CYCLES(4),
    .BASE_ADDR      (BASE)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .btn_raw    (btn_raw),
    .iomem_valid(iomem_valid),
    .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb),
    .iomem_addr (iomem_addr),
    .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called just after a falling edge; valid is held two cycles to show ready is a single pulse.
  task automatic bus(input string tag, input logic [31:0] addr, input logic [3:0] wstrb,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata);
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wstrb = wstrb;
    iomem_wdata = wdata;
    @(negedge clk);
    check({tag, "_rdy"}, {31'd0, iomem_ready}, 32'd1);
    check({tag, "_data"}, iomem_rdata, exp_rdata);
    @(negedge clk);
    check({tag, "_1cyc"}, {31'd0, iomem_ready}, 32'd0);
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn      = 1'b0;
    btn_raw     = '0;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0000;
    iomem_addr  = '0;
    iomem_wdata = '0;
    tick(2);
    check("rst_ready", {31'd0, iomem_ready}, 32'd0);
    check("rst_rdata", iomem_rdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    resetn = 1'b1;

    bus("rd_state_rst", BASE + 32'h0, 4'b0000, 32'd0, 32'h0);
    bus("rd_event_rst", BASE + 32'h4, 4'b0000, 32'd0, 32'h0);
    bus("rd_irqen_rst", BASE + 32'h8, 4'b0000, 32'd0, 32'h0);
    bus("wr_irqen", BASE + 32'h8, 4'b0001, 32'hFFFF_FFE4, 32'h0);
    bus("rd_irqen", BASE + 32'h8, 4'b0000, 32'd0, 32'h4);
    bus("wr_irqen_lane2", BASE + 32'h8, 4'b0100, 32'h0000_001F, 32'h4);
    bus("rd_irqen_lane2", BASE + 32'h8, 4'b0000, 32'd0, 32'h4);

    // Glitch of three cycles on button 0 must be filtered out.
    btn_raw = 5'b00001;
    tick(3);
    btn_raw = 5'b00000;
    tick(8);
    bus("glitch_state", BASE + 32'h0, 4'b0000, 32'd0, 32'h0);
    bus("glitch_event", BASE + 32'h4, 4'b0000, 32'd0, 32'h0);

    // Button 2 press: level at edge 6, EVENT at edge 7, irq follows EVENT & IRQ_EN.
    btn_raw = 5'b00100;
    tick(5);
    check("press_irq_early", {31'd0, irq}, 32'd0);
    bus("press_state_early", BASE + 32'h0, 4'b0000, 32'd0, 32'h0);
    check("press_irq", {31'd0, irq}, 32'd1);
    bus("press_state", BASE + 32'h0, 4'b0000, 32'd0, 32'h4);
    bus("press_event", BASE + 32'h4, 4'b0000, 32'd0, 32'h4);
    btn_raw = 5'b00000;
    bus("w1c_event2", BASE + 32'h4, 4'b0001, 32'h4, 32'h4);
    check("w1c_irq", {31'd0, irq}, 32'd0);
    bus("w1c_event2_rd", BASE + 32'h4, 4'b0000, 32'd0, 32'h0);

    // W1C of bit 0 lands on the same edge EVENT[0] sets: the set wins.
    btn_raw = 5'b00001;
    tick(6);
    bus("w1c_same_edge", BASE + 32'h4, 4'b0001, 32'h1, 32'h0);
    bus("set_wins_rd", BASE + 32'h4, 4'b0000, 32'd0, 32'h1);
    check("set_wins_irq", {31'd0, irq}, 32'd0);
    btn_raw = 5'b00000;
    bus("w1c_event0", BASE + 32'h4, 4'b0001, 32'h1, 32'h1);
    bus("w1c_event0_rd", BASE + 32'h4, 4'b0000, 32'd0, 32'h0);

    // Unmatched address held five cycles: no ready, no state change.
    iomem_valid = 1'b1;
    iomem_addr  = BASE + 32'h10;
    iomem_wstrb = 4'b0001;
    iomem_wdata = 32'h1F;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bad_addr_rdy", {31'd0, iomem_ready}, 32'd0);
    end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0000;
    bus("bad_addr_irqen", BASE + 32'h8, 4'b0000, 32'd0, 32'h4);
    bus("bad_addr_event", BASE + 32'h4, 4'b0000, 32'd0, 32'h0);

    // Reset asserted with irq high, a ready pulse out, and button 4 mid-debounce.
    btn_raw = 5'b01100;
    tick(4);
    btn_raw = 5'b11100;
    tick(3);
    check("pre_rst_irq", {31'd0, irq}, 32'd1);
    iomem_valid = 1'b1;
    iomem_addr  = BASE + 32'h0;
    iomem_wstrb = 4'b0000;
    @(posedge clk);
    #1;
    check("pre_rst_rdy", {31'd0, iomem_ready}, 32'd1);
    check("pre_rst_state", iomem_rdata, 32'h0C);
    #1;
    resetn = 1'b0;
    #1;
    check("async_rst_rdy", {31'd0, iomem_ready}, 32'd0);
    check("async_rst_rdata", iomem_rdata, 32'd0);
    check("async_rst_irq", {31'd0, irq}, 32'd0);
    iomem_valid = 1'b0;
    @(negedge clk);
    check("rst_hold_rdy", {31'd0, iomem_ready}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Buttons held through reset release debounce as fresh presses: EVENT at edge 7.
    tick(6);
    bus("held_event_early", BASE + 32'h4, 4'b0000, 32'd0, 32'h0);
    bus("held_event", BASE + 32'h4, 4'b0000, 32'd0, 32'h1C);
    bus("held_irqen", BASE + 32'h8, 4'b0000, 32'd0, 32'h0);
    check("held_irq", {31'd0, irq}, 32'd0);
    bus("wr_state", BASE + 32'h0, 4'b0011, 32'h0, 32'h1C);
    bus("wr_state_rd", BASE + 32'h0, 4'b0000, 32'd0, 32'h1C);

    btn_raw = 5'b00000;
    tick(10);
`ifdef BTN_RELEASE_EVENT_EN
    bus("w1c_rel_all", BASE + 32'hC, 4'b0001, 32'h1F, 32'h1C);
    bus("w1c_rel_all_rd", BASE + 32'hC, 4'b0000, 32'd0, 32'h0);
`endif
    bus("w1c_event_all", BASE + 32'h4, 4'b0001, 32'h1F, 32'h1C);
    bus("w1c_event_all_rd", BASE + 32'h4, 4'b0000, 32'd0, 32'h0);

    // Press and release button 1.
    btn_raw = 5'b00010;
    tick(8);
    bus("btn1_event", BASE + 32'h4, 4'b0000, 32'd0, 32'h2);
    btn_raw = 5'b00000;
    tick(8);
`ifdef BTN_RELEASE_EVENT_EN
    bus("rel_event", BASE + 32'hC, 4'b0000, 32'd0, 32'h2);
    bus("rel_irqen", BASE + 32'h8, 4'b0001, 32'h2, 32'h0);
    bus("rel_clr_event", BASE + 32'h4, 4'b0001, 32'h2, 32'h2);
    check("rel_irq", {31'd0, irq}, 32'd1);
    bus("rel_w1c", BASE + 32'hC, 4'b0001, 32'h2, 32'h2);
    check("rel_irq_clr", {31'd0, irq}, 32'd0);
`else
    iomem_valid = 1'b1;
    iomem_addr  = BASE + 32'hC;
    iomem_wstrb = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_rel_rdy", {31'd0, iomem_ready}, 32'd0);
    end
    iomem_valid = 1'b0;
    check("no_rel_irq", {31'd0, irq}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
